config_sequencer: RTL and testbench
===================================

Name: config_sequencer

Overview:
- Sequences run-time reconfiguration of instrumentation blocks (packer, filters, reducers) over the shared configId/configData byte bus.
- A host fills a byte buffer and issues a load request naming a target config ID.
- The block drops tracing, waits for the pipeline to drain, and streams the bytes with a counter-reset gap before and after.
- It then restores tracing. It sits between the host/JTAG register interface and every block sharing the config bus.

Parameters:
- MAX_BYTES, 16, byte-buffer depth; maximum bytes per load (packer needs 2*MAX_CHAINS).
- DRAIN_CYCLES, 4, cycles with tracing low and idle ID before the first byte; must be >=1.
- IDLE_ID, 8'hFF, config ID matched by no block; forces every block's byte counter to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write buffer byte
- wr_addr  in  $clog2(MAX_BYTES)  buffer index
- wr_data  in  8  buffer byte
- req_valid  in  1  load request
- req_ready  out  1  high only in IDLE
- req_target_id  in  8  config ID to load
- req_len  in  $clog2(MAX_BYTES+1)  number of bytes
- trace_enable_in  in  1  host tracing request
- tracing  out  1  to all blocks' tracing input
- configId  out  8  config bus ID
- configData  out  8  config bus data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, rejected request

Behaviour:
- Reset (rst_n=0 at posedge):
  - State becomes IDLE.
  - tracing=0, configId=IDLE_ID, configData=0, done=0, err=0, busy=0.
  - Read index cleared. Buffer contents are not cleared.
  - Reset mid-load aborts immediately; no further bytes are emitted.
- All outputs are registered. req_ready and busy are decoded from the state register.
- FSM states: IDLE, DRAIN, LOAD, GAP.
- IDLE:
  - tracing <= trace_enable_in (1-cycle latency); configId=IDLE_ID.
  - wr_en writes buf[wr_addr]; out-of-range wr_addr is ignored.
- Handshake: a request is accepted at a posedge where req_valid && req_ready. req_target_id and req_len are latched at that edge.
- Rejected requests:
  - Condition: req_len==0, req_len>MAX_BYTES, or req_target_id==IDLE_ID.
  - Response: err=1 on the next cycle, state stays IDLE, tracing is unaffected.
- IDLE->DRAIN on a valid acceptance:
  - tracing<=0, configId<=IDLE_ID.
  - Drain counter loaded with DRAIN_CYCLES-1.
- DRAIN:
  - tracing stays 0 and configId stays IDLE_ID for exactly DRAIN_CYCLES cycles.
  - Transitions to LOAD with configId<=target, configData<=buf[0].
- LOAD:
  - One byte per cycle: configId=target, configData=buf[i], i=0..len-1.
  - Exactly len cycles, then GAP.
- GAP:
  - 1 cycle with configId=IDLE_ID, configData=0, tracing=0.
  - Transitions to IDLE.
  - On that edge: done<=1 and tracing<=trace_enable_in.
- Latency: accept edge to done-high edge = DRAIN_CYCLES+len+1 cycles.
- Contiguous matching-ID window: exactly len cycles, bracketed by IDLE_ID. Targets therefore see byte_counter 0..len-1.
- wr_en while busy is ignored, so the buffer is stable during LOAD.
- trace_enable_in changes while busy are ignored; the value is sampled at the GAP->IDLE edge.
- req_valid while busy: req_ready=0, the request is not accepted, and the host holds it.
- Simultaneous wr_en and request acceptance in IDLE: the write takes effect; LOAD reads the updated byte.
- The index counter never wraps: i < len <= MAX_BYTES.

Decomposition:
- Shared package cfg_pkg:
  - state enum cfg_state_t {IDLE, DRAIN, LOAD, GAP}
  - constant CFG_IDLE_ID = 8'hFF
  - per-block PERSONAL_CONFIG_ID constants, so targets and sequencer agree.
- One sub-module: cfg_byte_buffer (MAX_BYTES x 8 register file, 1 write port, 1 async read port).

Test Plan:
- Packer load: rst, trace_enable_in=1; write buf={0,0,0,0,2,2,2,2}; request target=0, len=8, DRAIN_CYCLES=4 -> tracing low 13 cycles; configId: FF x4, 00 x8, FF x1; configData follows buf; done pulse at accept+13; tracing=1 next cycle. Connected packer firmware[0..3]=2 (pack-1 mode).
- Rejects: req_len=0, then 17, then target=8'hFF -> err pulse each, state stays IDLE, tracing stays 1, configId stays FF.
- Busy back-pressure: second request issued during LOAD -> req_ready=0; accepted only after done; wr_en during LOAD leaves the streamed bytes unchanged.
- Reset mid-LOAD: rst_n=0 after byte 3 -> next cycle configId=FF, tracing=0, busy=0, no done pulse; then a fresh len=2 load to target 5 completes normally.
- Tracing restore: trace_enable_in dropped to 0 during DRAIN -> tracing stays 0 after done; raised later -> tracing=1 one cycle after.
- Back-to-back: req_valid held high with two loads (len=1, target=3) -> second accept edge is the cycle after done; configId shows FF-bracketed single bytes, no merged ID window.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and config-bus IDs for the configuration sequencer
// and every block that listens on the configId/configData bus.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD,
        GAP
    } cfg_state_t;

    localparam logic [7:0] CFG_IDLE_ID = 8'hFF;

    // Personal IDs the instrumentation blocks match against
    localparam logic [7:0] PACKER_CONFIG_ID  = 8'h00;
    localparam logic [7:0] FILTER_CONFIG_ID  = 8'h01;
    localparam logic [7:0] REDUCER_CONFIG_ID = 8'h02;

endpackage

// File: rtl/config_sequencer_cfg_byte_buffer.sv
// Host-written byte store streamed out on the config bus.
// One synchronous write port, one asynchronous read port.
module cfg_byte_buffer #(
    parameter int MAX_BYTES = 16,
    parameter int AW        = $clog2(MAX_BYTES)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MAX_BYTES];

    // Addresses past the buffer depth are dropped
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < MAX_BYTES)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/config_sequencer.sv
// Drops tracing, drains, streams a byte buffer to one config ID
// bracketed by idle-ID cycles, then restores tracing.
module config_sequencer
    import cfg_pkg::*;
#(
    parameter int          MAX_BYTES    = 16,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [7:0]  IDLE_ID      = CFG_IDLE_ID,
    localparam int         AW           = $clog2(MAX_BYTES),
    localparam int         LW           = $clog2(MAX_BYTES + 1),
    localparam int         DW           = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [7:0]    req_target_id,
    input  logic [LW-1:0] req_len,
    input  logic          trace_enable_in,
    output logic          tracing,
    output logic [7:0]    configId,
    output logic [7:0]    configData,
    output logic          busy,
    output logic          done,
    output logic          err
);

    cfg_state_t    state, state_d;
    logic [DW-1:0] drain_cnt, drain_d;
    logic [LW-1:0] idx, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    tgt_q, tgt_d;
    logic          tracing_d, done_d, err_d;
    logic [7:0]    id_d, data_d;
    logic [7:0]    rd_data;
    logic          bad_req;

    cfg_byte_buffer #(
        .MAX_BYTES(MAX_BYTES),
        .AW       (AW)
    ) u_buf (
        .clk    (clk),
        .wr_en  (wr_en && (state == IDLE)),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(idx[AW-1:0]),
        .rd_data(rd_data)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign bad_req = (req_len == '0)
                  || (int'(req_len) > MAX_BYTES)
                  || (req_target_id == IDLE_ID);

    always_comb begin
        state_d   = state;
        drain_d   = drain_cnt;
        idx_d     = idx;
        len_d     = len_q;
        tgt_d     = tgt_q;
        tracing_d = tracing;
        id_d      = configId;
        data_d    = configData;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state)
            IDLE: begin
                tracing_d = trace_enable_in;
                id_d      = IDLE_ID;
                data_d    = 8'h00;
                if (req_valid) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = DRAIN;
                        tracing_d = 1'b0;
                        drain_d   = DW'(DRAIN_CYCLES - 1);
                        idx_d     = '0;
                        tgt_d     = req_target_id;
                        len_d     = req_len;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = LOAD;
                    id_d    = tgt_q;
                    data_d  = rd_data;
                    idx_d   = idx + 1'b1;
                end else begin
                    drain_d = drain_cnt - 1'b1;
                end
            end
            LOAD: begin
                // idx already points one past the byte on the bus
                if (idx == len_q) begin
                    state_d = GAP;
                    id_d    = IDLE_ID;
                    data_d  = 8'h00;
                end else begin
                    id_d   = tgt_q;
                    data_d = rd_data;
                    idx_d  = idx + 1'b1;
                end
            end
            GAP: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                tracing_d = trace_enable_in;
                id_d      = IDLE_ID;
                data_d    = 8'h00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            idx        <= '0;
            len_q      <= '0;
            tgt_q      <= '0;
            tracing    <= 1'b0;
            configId   <= IDLE_ID;
            configData <= 8'h00;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            drain_cnt  <= drain_d;
            idx        <= idx_d;
            len_q      <= len_d;
            tgt_q      <= tgt_d;
            tracing    <= tracing_d;
            configId   <= id_d;
            configData <= data_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// Randomized self-checking bench for config_sequencer against a
// cycle-timeline model derived from the load protocol.
module tb_config_sequencer;
    import cfg_pkg::*;

    localparam int         MB = 16;
    localparam int         D  = 4;
    localparam logic [7:0] FF = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_target_id = '0;
    logic [4:0] req_len = '0;
    logic       trace_enable_in = 1'b0;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl [MB];

    always #5 clk = ~clk;

    config_sequencer #(
        .MAX_BYTES   (MB),
        .DRAIN_CYCLES(D),
        .IDLE_ID     (FF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_target_id  (req_target_id),
        .req_len        (req_len),
        .trace_enable_in(trace_enable_in),
        .tracing        (tracing),
        .configId       (configId),
        .configData     (configData),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Writes one byte while idle; entered and left at a negedge
    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        mdl[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trace_enable_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({tracing, configId, configData, done, err, busy, req_ready}
            !== {1'b0, FF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got tr=%b id=%h d=%h dn=%b er=%b bz=%b rdy=%b want 0 ff 00 0 0 0 1",
                     tracing, configId, configData, done, err, busy, req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tracing !== 1'b1) begin
            errors++;
            $display("FAIL reset_trace_follow got %b want 1", tracing);
        end
    endtask

    // Full load timeline from the request cycle to one cycle past done
    task automatic test_load(input string name, input logic [7:0] tgt,
                             input int len, input logic te,
                             input logic te_late, input logic wr_same,
                             input logic [7:0] wr_val);
        logic       e_busy, e_done, e_tr;
        logic [7:0] e_id, e_d;
        trace_enable_in = te;
        req_valid = 1'b1;
        req_target_id = tgt;
        req_len = 5'(len);
        if (wr_same) begin
            wr_en = 1'b1;
            wr_addr = 4'd0;
            wr_data = wr_val;
            mdl[0] = wr_val;
        end
        for (int k = 0; k <= D + len + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0;
                wr_en = 1'b0;
            end
            if (k == 1) trace_enable_in = te_late;
            e_busy = (k <= D + len);
            e_done = (k == D + len + 1);
            e_tr = (k > D + len) ? te_late : 1'b0;
            e_id = (k >= D && k < D + len) ? tgt : FF;
            checks++;
            if ({busy, req_ready, tracing, done, err, configId}
                !== {e_busy, ~e_busy, e_tr, e_done, 1'b0, e_id}) begin
                errors++;
                $display("FAIL %s k=%0d got bz=%b rdy=%b tr=%b dn=%b er=%b id=%h want bz=%b tr=%b dn=%b id=%h",
                         name, k, busy, req_ready, tracing, done, err, configId,
                         e_busy, e_tr, e_done, e_id);
            end
            if (k >= D && k <= D + len) begin
                e_d = (k < D + len) ? mdl[k-D] : 8'h00;
                checks++;
                if (configData !== e_d) begin
                    errors++;
                    $display("FAIL %s_data k=%0d got %h want %h",
                             name, k, configData, e_d);
                end
            end
        end
    endtask

    task automatic test_packer();
        logic [7:0] pat [8];
        pat = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2};
        for (int a = 0; a < 8; a++) poke(4'(a), pat[a]);
        test_load("packer", PACKER_CONFIG_ID, 8, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_rejects();
        trace_enable_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_target_id = 8'($urandom_range(0, 254));
            case (i)
                0: req_len = 5'd0;
                1: req_len = 5'd17;
                2: begin req_len = 5'd4; req_target_id = FF; end
                default: req_len = 5'($urandom_range(18, 31));
            endcase
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if ({err, busy, req_ready, tracing, configId}
                !== {1'b1, 1'b0, 1'b1, 1'b1, FF}) begin
                errors++;
                $display("FAIL reject%0d got er=%b bz=%b rdy=%b tr=%b id=%h want 1 0 1 1 ff",
                         i, err, busy, req_ready, tracing, configId);
            end
            @(negedge clk);
            checks++;
            if ({err, busy} !== 2'b00) begin
                errors++;
                $display("FAIL reject%0d_after got er=%b bz=%b want 0 0", i, err, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] t1, t2, e_id;
        t1 = 8'($urandom_range(0, 254));
        t2 = 8'($urandom_range(0, 254));
        for (int a = 0; a < 4; a++) poke(4'(a), 8'($urandom));
        trace_enable_in = 1'b1;
        req_valid = 1'b1;
        req_target_id = t1;
        req_len = 5'd4;
        for (int k = 0; k <= D + 5; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e_id = (k >= D && k < D + 4) ? t1 : FF;
            checks++;
            if ({req_ready, done, configId} !== {k == D + 5, k == D + 5, e_id}) begin
                errors++;
                $display("FAIL bp_first k=%0d got rdy=%b dn=%b id=%h want %b %b %h",
                         k, req_ready, done, configId, k == D + 5, k == D + 5, e_id);
            end
            if (k >= D && k < D + 4) begin
                checks++;
                if (configData !== mdl[k-D]) begin
                    errors++;
                    $display("FAIL bp_first_data k=%0d got %h want %h",
                             k, configData, mdl[k-D]);
                end
            end
            wr_en = 1'b0;
            if (k == D + 1) begin
                wr_en = 1'b1;
                wr_addr = 4'd3;
                wr_data = ~mdl[3];
                req_valid = 1'b1;
                req_target_id = t2;
                req_len = 5'd2;
            end
        end
        for (int k = 0; k <= D + 3; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            e_id = (k >= D && k < D + 2) ? t2 : FF;
            checks++;
            if ({busy, done, configId} !== {k <= D + 2, k == D + 3, e_id}) begin
                errors++;
                $display("FAIL bp_second k=%0d got bz=%b dn=%b id=%h want %b %b %h",
                         k, busy, done, configId, k <= D + 2, k == D + 3, e_id);
            end
            if (k >= D && k < D + 2) begin
                checks++;
                if (configData !== mdl[k-D]) begin
                    errors++;
                    $display("FAIL bp_second_data k=%0d got %h want %h",
                             k, configData, mdl[k-D]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mdl[3] === 8'hxx) begin
                errors++;
                $display("FAIL bp_model byte3 undefined");
            end
            break;
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] tgt;
        tgt = 8'($urandom_range(0, 254));
        for (int a = 0; a < 6; a++) poke(4'(a), 8'($urandom));
        trace_enable_in = 1'b1;
        req_valid = 1'b1;
        req_target_id = tgt;
        req_len = 5'd6;
        for (int k = 0; k <= D + 3; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
        end
        checks++;
        if ({configId, configData} !== {tgt, mdl[3]}) begin
            errors++;
            $display("FAIL midrst_byte3 got %h/%h want %h/%h",
                     configId, configData, tgt, mdl[3]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({configId, tracing, busy, done} !== {FF, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_state got id=%h tr=%b bz=%b dn=%b want ff 0 0 0",
                     configId, tracing, busy, done);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({done, busy, configId} !== {1'b0, 1'b0, FF}) begin
                errors++;
                $display("FAIL midrst_quiet k=%0d got dn=%b bz=%b id=%h want 0 0 ff",
                         k, done, busy, configId);
            end
        end
        test_load("after_reset", 8'd5, 2, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_trace_restore();
        test_load("trace_drop", 8'($urandom_range(0, 254)), 3,
                  1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (tracing !== 1'b0) begin
            errors++;
            $display("FAIL trace_stays_low got %b want 0", tracing);
        end
        trace_enable_in = 1'b1;
        @(negedge clk);
        checks++;
        if (tracing !== 1'b1) begin
            errors++;
            $display("FAIL trace_raise got %b want 1", tracing);
        end
    endtask

    task automatic test_back_to_back();
        int j;
        int p;
        logic [7:0] e_id;
        p = D + 3;
        poke(4'd0, 8'($urandom));
        trace_enable_in = 1'b1;
        req_valid = 1'b1;
        req_target_id = 8'd3;
        req_len = 5'd1;
        for (int k = 0; k < 2 * p; k++) begin
            @(negedge clk);
            if (k == p) req_valid = 1'b0;
            j = k % p;
            e_id = (j == D) ? 8'd3 : FF;
            checks++;
            if ({busy, done, configId} !== {j <= D + 1, j == D + 2, e_id}) begin
                errors++;
                $display("FAIL b2b k=%0d got bz=%b dn=%b id=%h want %b %b %h",
                         k, busy, done, configId, j <= D + 1, j == D + 2, e_id);
            end
            if (j == D) begin
                checks++;
                if (configData !== mdl[0]) begin
                    errors++;
                    $display("FAIL b2b_data k=%0d got %h want %h",
                             k, configData, mdl[0]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_third got bz=%b want 0", busy);
        end
    endtask

    task automatic test_random_loads();
        for (int n = 0; n < 6; n++) begin
            for (int a = 0; a < MB; a++) poke(4'(a), 8'($urandom));
            test_load("random", 8'($urandom_range(0, 254)),
                      int'($urandom_range(1, MB)),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_packer();
        test_rejects();
        test_backpressure();
        test_reset_mid_load();
        test_trace_restore();
        test_back_to_back();
        test_random_loads();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
